// File: rtl/uart_tx_fifo.sv
// Generic single-clock FIFO, registered pointers and occupancy.
// Latency: a write is visible on rd_dat the cycle after it is accepted.
// Backpressure: wr_rdy drops when full; rd_vld drops when empty.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   wr_vld,
    output logic                   wr_rdy,
    input  logic [W-1:0]           wr_dat,
    output logic                   rd_vld,
    input  logic                   rd_rdy,
    output logic [W-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign wr_rdy = (level != (AW+1)'(DEPTH));
    assign rd_vld = (level != '0);
    assign do_wr  = wr_vld && wr_rdy;
    assign do_rd  = rd_rdy && rd_vld;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end
endmodule

// UART transmitter with TX FIFO, configurable width, parity and stop bits.
// Latency: first start bit on the first baud_tick after a word is queued with en=1.
// Backpressure: s_ready = !full (0 in reset); frames chain back-to-back while data remains.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          en,
    input  logic                          baud_tick,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state_q, state_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] data_q;
    logic [DATA_BITS-1:0] head;
    logic                 fifo_vld;
    logic                 fifo_rdy;
    logic                 pop;
    logic                 tx_d;

    fifo #(
        .W     (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .arst_n (arst_n),
        .wr_vld (s_valid),
        .wr_rdy (fifo_rdy),
        .wr_dat (s_data),
        .rd_vld (fifo_vld),
        .rd_rdy (pop),
        .rd_dat (head),
        .level  (fifo_level)
    );

    assign s_ready = fifo_rdy && arst_n;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            data_q     <= '0;
            tx         <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx         <= tx_d;
            if (pop) data_q <= head;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        pop        = 1'b0;
        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (en && fifo_vld) begin
                        state_d = S_START;
                        pop     = 1'b1;
                    end
                end
                S_START: begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
                S_DATA: begin
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                        state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
                S_PARITY: begin
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                end
                S_STOP: begin
                    // Final stop period chains straight into the next start bit.
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        if (en && fifo_vld) begin
                            state_d = S_START;
                            pop     = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        tx_d = tx;
        if (baud_tick) begin
            case (state_d)
                S_START:  tx_d = 1'b0;
                S_DATA:   tx_d = data_q[bit_cnt_d];
                S_PARITY: tx_d = (^data_q) ^ (PARITY == 2);
                default:  tx_d = 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (even/1 stop, odd/1 stop, none/2 stop),
// a tick-driven line monitor checking each frame against a scoreboard of queued words.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          en = 1'b0;
    logic          baud_tick = 1'b0;
    logic [7:0]    s_data = '0;
    logic [NI-1:0] s_valid = '0;
    logic [NI-1:0] s_ready;
    logic [NI-1:0] tx;
    logic [NI-1:0] busy;
    logic [2:0]    lvl [NI];

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];
    logic [7:0] exp_q2 [$];
    int         m_pos  [NI];
    logic [7:0] m_word [NI];
    bit         m_have [NI];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_even (
        .clk(clk), .arst_n(arst_n), .en(en), .baud_tick(baud_tick), .s_data(s_data),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .tx(tx[0]), .busy(busy[0]), .fifo_level(lvl[0]));
    uart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_odd (
        .clk(clk), .arst_n(arst_n), .en(en), .baud_tick(baud_tick), .s_data(s_data),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .tx(tx[1]), .busy(busy[1]), .fifo_level(lvl[1]));
    uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_stop2 (
        .clk(clk), .arst_n(arst_n), .en(en), .baud_tick(baud_tick), .s_data(s_data),
        .s_valid(s_valid[2]), .s_ready(s_ready[2]), .tx(tx[2]), .busy(busy[2]), .fifo_level(lvl[2]));

    // One baud tick every 4 clocks.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            baud_tick = (cnt == 3);
            cnt = (cnt + 1) % 4;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic int par_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 0;
    endfunction

    function automatic int stop_of(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int k);
        return 1 + 8 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k);
    endfunction

    function automatic logic frame_bit(input int k, input logic [7:0] w, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return w[pos-1];
        if (pos == 9 && par_of(k) != 0) return (par_of(k) == 1) ? (^w) : ~(^w);
        return 1'b1;
    endfunction

    task automatic push_exp(input int k, input logic [7:0] w);
        case (k)
            0:       exp_q0.push_back(w);
            1:       exp_q1.push_back(w);
            default: exp_q2.push_back(w);
        endcase
    endtask

    task automatic pop_exp(input int k, output bit ok, output logic [7:0] w);
        ok = 1'b0;
        w  = '0;
        case (k)
            0:       if (exp_q0.size() > 0) begin w = exp_q0.pop_front(); ok = 1'b1; end
            1:       if (exp_q1.size() > 0) begin w = exp_q1.pop_front(); ok = 1'b1; end
            default: if (exp_q2.size() > 0) begin w = exp_q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic clear_scoreboard();
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        for (int k = 0; k < NI; k++) m_pos[k] = -1;
    endtask

    task automatic mon_step(input int k);
        logic exp_b;
        if (m_pos[k] < 0) begin
            if (tx[k] === 1'b0) begin
                m_pos[k] = 0;
                pop_exp(k, m_have[k], m_word[k]);
                checks++;
                if (!m_have[k]) begin
                    errors++;
                    $display("FAIL unexpected_start inst %0d: tx=0 but no queued word expected", k);
                end
                checks++;
                if (busy[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_at_start inst %0d: busy=%b required 1", k, busy[k]);
                end
            end
        end else begin
            m_pos[k]++;
            if (m_have[k]) begin
                exp_b = frame_bit(k, m_word[k], m_pos[k]);
                checks++;
                if (tx[k] !== exp_b) begin
                    errors++;
                    $display("FAIL frame_bit inst %0d word %02h pos %0d: tx=%b required %b",
                             k, m_word[k], m_pos[k], tx[k], exp_b);
                end
            end
            checks++;
            if (busy[k] !== 1'b1) begin
                errors++;
                $display("FAIL busy_in_frame inst %0d pos %0d: busy=%b required 1", k, m_pos[k], busy[k]);
            end
            if (m_pos[k] == frame_len(k) - 1) m_pos[k] = -1;
        end
    endtask

    always @(posedge clk) begin
        if (baud_tick && arst_n) begin
            #1;
            for (int k = 0; k < NI; k++) mon_step(k);
        end
    end

    task automatic wait_tick();
        do @(posedge clk); while (baud_tick !== 1'b1);
        #1;
    endtask

    task automatic push_word(input int k, input logic [7:0] w, input logic accept);
        @(negedge clk);
        s_data     = w;
        s_valid[k] = 1'b1;
        checks++;
        if (s_ready[k] !== accept) begin
            errors++;
            $display("FAIL s_ready inst %0d word %02h: s_ready=%b required %b", k, w, s_ready[k], accept);
        end
        if (accept) push_exp(k, w);
        @(posedge clk);
        #1;
        s_valid[k] = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        en     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (tx[k] !== 1'b1) begin errors++; $display("FAIL reset_tx inst %0d: tx=%b required 1", k, tx[k]); end
            checks++;
            if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy inst %0d: busy=%b required 0", k, busy[k]); end
            checks++;
            if (lvl[k] !== 3'd0) begin errors++; $display("FAIL reset_level inst %0d: level=%0d required 0", k, lvl[k]); end
            checks++;
            if (s_ready[k] !== 1'b0) begin errors++; $display("FAIL reset_ready inst %0d: s_ready=%b required 0", k, s_ready[k]); end
        end
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (s_ready[k] !== 1'b1) begin errors++; $display("FAIL ready_after_reset inst %0d: s_ready=%b required 1", k, s_ready[k]); end
        end
    endtask

    task automatic test_parity_frames();
        int         ks [2];
        logic [7:0] ws [2];
        logic [10:0] ev [2];
        logic [10:0] got;
        int          busy_lo;
        ks[0] = 0; ws[0] = 8'hB4; ev[0] = 11'b1_0_10110100_0;
        ks[1] = 1; ws[1] = 8'hA5; ev[1] = 11'b1_1_10100101_0;
        en = 1'b1;
        for (int c = 0; c < 2; c++) begin
            wait_tick();
            push_word(ks[c], ws[c], 1'b1);
            checks++;
            if (lvl[ks[c]] !== 3'd1) begin errors++; $display("FAIL parity_level_queued inst %0d: level=%0d required 1", ks[c], lvl[ks[c]]); end
            wait_tick();
            got[0] = tx[ks[c]];
            checks++;
            if (lvl[ks[c]] !== 3'd0) begin errors++; $display("FAIL parity_level_start inst %0d: level=%0d required 0", ks[c], lvl[ks[c]]); end
            busy_lo = (busy[ks[c]] === 1'b1) ? 0 : 1;
            for (int i = 1; i < 11; i++) begin
                wait_tick();
                got[i] = tx[ks[c]];
                if (busy[ks[c]] !== 1'b1) busy_lo++;
            end
            checks++;
            if (got !== ev[c]) begin errors++; $display("FAIL parity_frame inst %0d word %02h: got %b required %b", ks[c], ws[c], got, ev[c]); end
            checks++;
            if (busy_lo != 0) begin errors++; $display("FAIL parity_busy inst %0d: busy low on %0d of 11 ticks, required 0", ks[c], busy_lo); end
            wait_tick();
            checks++;
            if (busy[ks[c]] !== 1'b0 || tx[ks[c]] !== 1'b1) begin
                errors++;
                $display("FAIL parity_idle inst %0d: busy=%b tx=%b required busy=0 tx=1", ks[c], busy[ks[c]], tx[ks[c]]);
            end
        end
    endtask

    task automatic test_fifo_full();
        int gaps;
        en = 1'b0;
        wait_tick();
        for (int i = 1; i <= 4; i++) begin
            push_word(0, 8'(i), 1'b1);
            checks++;
            if (lvl[0] !== 3'(i)) begin errors++; $display("FAIL full_fill_level after %0d: level=%0d required %0d", i, lvl[0], i); end
        end
        push_word(0, 8'h05, 1'b0);
        checks++;
        if (lvl[0] !== 3'd4) begin errors++; $display("FAIL full_dropped_level: level=%0d required 4", lvl[0]); end
        en = 1'b1;
        wait_tick();
        checks++;
        if (busy[0] !== 1'b1 || lvl[0] !== 3'd3) begin
            errors++;
            $display("FAIL full_first_start: busy=%b level=%0d required busy=1 level=3", busy[0], lvl[0]);
        end
        gaps = 0;
        for (int i = 0; i < 43; i++) begin
            wait_tick();
            if (busy[0] !== 1'b1) gaps++;
        end
        checks++;
        if (gaps != 0) begin errors++; $display("FAIL full_back_to_back: busy low on %0d ticks required 0", gaps); end
        wait_tick();
        checks++;
        if (busy[0] !== 1'b0 || lvl[0] !== 3'd0) begin
            errors++;
            $display("FAIL full_drain_idle: busy=%b level=%0d required busy=0 level=0", busy[0], lvl[0]);
        end
    endtask

    task automatic test_two_stop();
        logic [21:0] seq;
        logic [21:0] ev;
        int          gaps;
        ev = {2'b11, 8'hC3, 1'b0, 2'b11, 8'h3C, 1'b0};
        en = 1'b1;
        wait_tick();
        push_word(2, 8'h3C, 1'b1);
        push_word(2, 8'hC3, 1'b1);
        gaps = 0;
        for (int i = 0; i < 22; i++) begin
            wait_tick();
            seq[i] = tx[2];
            if (busy[2] !== 1'b1) gaps++;
        end
        checks++;
        if (seq !== ev) begin errors++; $display("FAIL two_stop_sequence: got %b required %b", seq, ev); end
        checks++;
        if (gaps != 0) begin errors++; $display("FAIL two_stop_busy: busy low on %0d ticks required 0", gaps); end
        wait_tick();
        checks++;
        if (busy[2] !== 1'b0 || tx[2] !== 1'b1) begin
            errors++;
            $display("FAIL two_stop_idle: busy=%b tx=%b required busy=0 tx=1", busy[2], tx[2]);
        end
    endtask

    task automatic test_en_mid_frame();
        en = 1'b1;
        wait_tick();
        push_word(0, 8'h5A, 1'b1);
        push_word(0, 8'h81, 1'b1);
        wait_tick();
        checks++;
        if (lvl[0] !== 3'd1 || tx[0] !== 1'b0) begin
            errors++;
            $display("FAIL en_first_start: level=%0d tx=%b required level=1 tx=0", lvl[0], tx[0]);
        end
        repeat (3) wait_tick();
        en = 1'b0;
        repeat (8) wait_tick();
        checks++;
        if (busy[0] !== 1'b0 || lvl[0] !== 3'd1) begin
            errors++;
            $display("FAIL en_frame_done: busy=%b level=%0d required busy=0 level=1", busy[0], lvl[0]);
        end
        repeat (3) wait_tick();
        checks++;
        if (busy[0] !== 1'b0 || lvl[0] !== 3'd1 || tx[0] !== 1'b1) begin
            errors++;
            $display("FAIL en_held_idle: busy=%b level=%0d tx=%b required 0/1/1", busy[0], lvl[0], tx[0]);
        end
        en = 1'b1;
        wait_tick();
        checks++;
        if (busy[0] !== 1'b1 || tx[0] !== 1'b0 || lvl[0] !== 3'd0) begin
            errors++;
            $display("FAIL en_resume_start: busy=%b tx=%b level=%0d required 1/0/0", busy[0], tx[0], lvl[0]);
        end
        repeat (11) wait_tick();
        checks++;
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL en_resume_idle: busy=%b required 0", busy[0]); end
    endtask

    task automatic test_reset_mid_frame();
        en = 1'b1;
        wait_tick();
        push_word(1, 8'h11, 1'b1);
        push_word(1, 8'h22, 1'b1);
        push_word(1, 8'h33, 1'b1);
        wait_tick();
        checks++;
        if (lvl[1] !== 3'd2) begin errors++; $display("FAIL rst_mid_level_start: level=%0d required 2", lvl[1]); end
        repeat (3) wait_tick();
        @(negedge clk);
        arst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (tx[1] !== 1'b1 || busy[1] !== 1'b0 || lvl[1] !== 3'd0) begin
            errors++;
            $display("FAIL rst_mid_abort: tx=%b busy=%b level=%0d required 1/0/0", tx[1], busy[1], lvl[1]);
        end
        clear_scoreboard();
        @(negedge clk);
        arst_n = 1'b1;
        repeat (20) wait_tick();
        checks++;
        if (tx[1] !== 1'b1 || busy[1] !== 1'b0 || lvl[1] !== 3'd0) begin
            errors++;
            $display("FAIL rst_mid_quiet: tx=%b busy=%b level=%0d required 1/0/0", tx[1], busy[1], lvl[1]);
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            m_pos[k]  = -1;
            m_word[k] = '0;
            m_have[k] = 1'b0;
        end
        test_reset();
        test_parity_frames();
        test_fifo_full();
        test_two_stop();
        test_en_mid_frame();
        test_reset_mid_frame();
        checks++;
        if (exp_q0.size() + exp_q1.size() + exp_q2.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: %0d words never transmitted, required 0",
                     exp_q0.size() + exp_q1.size() + exp_q2.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
